// File: rtl/lfp_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : lfp_mac_accumulator
// Description : Sequential accumulator behind the LFP MAC adder. Sums VEC_LEN
//               signed Q6.11 partial sums into one dot product. The final sum
//               is saturated to Q6.11 and held on a valid/ready output.
//               Optional macro LFP_ACC_BIAS_EN adds a loadable bias register.
//               When the macro is defined, that bias seeds the accumulator at
//               the start of each vector.
// Revision    : 1.0 - initial release
// ============================================================================
module lfp_mac_accumulator #(
    parameter int VEC_LEN = 16,
    parameter int ACC_W   = 18 + $clog2(VEC_LEN)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] in_q,
`ifdef LFP_ACC_BIAS_EN
    input  logic [17:0] bias_q,
    input  logic        bias_load,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] out_q,
    output logic        out_sat,
    output logic        busy
);

    localparam int c_CNT_W = $clog2(VEC_LEN);
`ifdef LFP_ACC_BIAS_EN
    // One extra bit so that the bias term plus VEC_LEN full-scale samples
    // cannot wrap.
    localparam int c_SUM_W = ACC_W + 1;
`else
    localparam int c_SUM_W = ACC_W;
`endif
    localparam logic [c_CNT_W-1:0]        c_LAST     = c_CNT_W'(VEC_LEN - 1);
    localparam logic signed [c_SUM_W-1:0] c_SAT_MAX  = c_SUM_W'(131071);
    localparam logic signed [c_SUM_W-1:0] c_SAT_MIN  = c_SUM_W'(-131072);
    localparam logic [17:0]               c_Q_MAX    = 18'h1FFFF;
    localparam logic [17:0]               c_Q_MIN    = 18'h20000;

    localparam logic [0:0] c_ST_ACCUM = 1'b0;
    localparam logic [0:0] c_ST_HOLD  = 1'b1;

    logic [0:0]                r_state;
    logic [0:0]                w_state_nxt;
    logic [c_CNT_W-1:0]        r_count;
    logic signed [c_SUM_W-1:0] r_acc;
    logic                      r_out_valid;
    logic [17:0]               r_out_q;
    logic                      r_out_sat;

    logic                      w_xfer;
    logic                      w_last;
    logic signed [c_SUM_W-1:0] w_in_ext;
    logic signed [c_SUM_W-1:0] w_acc_base;
    logic signed [c_SUM_W-1:0] w_acc_clear;
    logic signed [c_SUM_W-1:0] w_final;
    logic                      w_ovf_hi;
    logic                      w_ovf_lo;
    logic [17:0]               w_sat_q;

    assign w_xfer   = in_valid && (r_state == c_ST_ACCUM);
    assign w_last   = w_xfer && (r_count == c_LAST);
    assign w_in_ext = {{(c_SUM_W - 18){in_q[17]}}, in_q};

`ifdef LFP_ACC_BIAS_EN
    logic [17:0] r_bias;
    logic        w_bias_ld;

    // A bias load applies only at the start of a vector. When it coincides
    // with the first sample, the new bias takes the place of the stale
    // accumulator value.
    assign w_bias_ld   = bias_load && (r_state == c_ST_ACCUM) && (r_count == '0);
    assign w_acc_base  = w_bias_ld ? {{(c_SUM_W - 18){bias_q[17]}}, bias_q} : r_acc;
    assign w_acc_clear = {{(c_SUM_W - 18){r_bias[17]}}, r_bias};

    // Bias register persists across vectors until reloaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bias <= '0;
        end else if (w_bias_ld) begin
            r_bias <= bias_q;
        end
    end
`else
    assign w_acc_base  = r_acc;
    assign w_acc_clear = '0;
`endif

    assign w_final  = w_acc_base + w_in_ext;
    assign w_ovf_hi = (w_final > c_SAT_MAX);
    assign w_ovf_lo = (w_final < c_SAT_MIN);
    assign w_sat_q  = w_ovf_hi ? c_Q_MAX : (w_ovf_lo ? c_Q_MIN : w_final[17:0]);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: HOLD after the last sample, ACCUM after the output handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_ACCUM: if (w_last) w_state_nxt = c_ST_HOLD;
            c_ST_HOLD:  if (r_out_valid && out_ready) w_state_nxt = c_ST_ACCUM;
            default:    w_state_nxt = c_ST_ACCUM;
        endcase
    end

    // Accumulate samples, capture the saturated result, and retire it on handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_q     <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (w_last) begin
                r_acc       <= w_acc_clear;
                r_count     <= '0;
                r_out_valid <= 1'b1;
                r_out_q     <= w_sat_q;
                r_out_sat   <= w_ovf_hi || w_ovf_lo;
            end else if (w_xfer) begin
                r_acc   <= w_final;
                r_count <= r_count + c_CNT_W'(1);
            end else begin
                r_acc   <= w_acc_base;
            end
            if ((r_state == c_ST_HOLD) && r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == c_ST_ACCUM);
    assign out_valid = r_out_valid;
    assign out_q     = r_out_q;
    assign out_sat   = r_out_sat;
    assign busy      = (r_count != '0) || (r_state == c_ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_lfp_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfp_mac_accumulator
// Description : Directed self-checking bench for lfp_mac_accumulator. It
//               covers reset, unity, mixed-sign, saturation, backpressure,
//               gapped input, and mid-operation reset. When LFP_ACC_BIAS_EN is
//               defined, it also covers the bias feature.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfp_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_q;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_q;
    logic        out_sat;
    logic        busy;
`ifdef LFP_ACC_BIAS_EN
    logic [17:0] bias_q;
    logic        bias_load;
`endif

    int errors = 0;
    int checks = 0;

    lfp_mac_accumulator #(.VEC_LEN(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
`ifdef LFP_ACC_BIAS_EN
        .bias_q    (bias_q),
        .bias_load (bias_load),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream n back-to-back transfers of value v.
    task automatic send_vec(input logic [17:0] v, input int n);
        in_valid = 1'b1;
        in_q     = v;
        repeat (n) tick();
        in_valid = 1'b0;
    endtask

    // Wait for a result (bounded), check it, then allow one handshake cycle.
    task automatic collect(input string tag, input logic [17:0] exp_q, input logic exp_sat);
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_q"}, {14'd0, out_q}, {14'd0, exp_q});
        chk({tag, "_sat"}, {31'd0, out_sat}, {31'd0, exp_sat});
        tick();
    endtask

    initial begin
        logic [17:0] hold_q;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_q      = '0;
        out_ready = 1'b1;
`ifdef LFP_ACC_BIAS_EN
        bias_q    = '0;
        bias_load = 1'b0;
`endif
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_q", {14'd0, out_q}, 32'd0);
        chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Unity: 16 x 1.0 = 16.0, exact latency
        in_valid = 1'b1;
        in_q     = 18'h00800;
        tick();
        chk("unity_busy_first", {31'd0, busy}, 32'd1);
        chk("unity_no_early_valid", {31'd0, out_valid}, 32'd0);
        repeat (15) tick();
        in_valid = 1'b0;
        chk("unity_valid", {31'd0, out_valid}, 32'd1);
        chk("unity_q", {14'd0, out_q}, 32'h08000);
        chk("unity_sat", {31'd0, out_sat}, 32'd0);
        chk("unity_in_ready_hold", {31'd0, in_ready}, 32'd0);
        tick();
        chk("unity_valid_clear", {31'd0, out_valid}, 32'd0);
        chk("unity_in_ready_back", {31'd0, in_ready}, 32'd1);
        chk("unity_busy_idle", {31'd0, busy}, 32'd0);

        // Mixed signs: 8 x 2048 + 8 x -1024 = 8192
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_q = (i % 2 == 0) ? 18'h00800 : 18'h3FC00;
            tick();
        end
        in_valid = 1'b0;
        collect("mixed", 18'h02000, 1'b0);

        // Saturation high, low, then clean zero vector
        send_vec(18'h1FFFF, 16);
        collect("sat_hi", 18'h1FFFF, 1'b1);
        send_vec(18'h20000, 16);
        collect("sat_lo", 18'h20000, 1'b1);
        send_vec(18'h00000, 16);
        collect("zeros", 18'h00000, 1'b0);

        // Backpressure: 16 x 0.5 = 8.0 held for 5 cycles, input pulses ignored
        out_ready = 1'b0;
        send_vec(18'h00400, 16);
        hold_q = 18'h04000;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_q     = 18'h00800;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_q_stable", {14'd0, out_q}, {14'd0, hold_q});
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_released", {31'd0, out_valid}, 32'd0);
        chk("bp_count_zero", {31'd0, busy}, 32'd0);

        // Gapped vector: sum of i*64 for i=0..15 = 7680
        for (int i = 0; i < 16; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_q     = 18'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_q     = 18'(i * 64);
            tick();
        end
        in_valid = 1'b0;
        collect("gaps", 18'h01E00, 1'b0);

        // Reset after 7 samples discards the partial sum
        send_vec(18'h00800, 7);
        chk("midrst_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);

        // Reset while holding a result drops it
        out_ready = 1'b0;
        send_vec(18'h00800, 16);
        chk("holdrst_pre_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("holdrst_valid", {31'd0, out_valid}, 32'd0);
        chk("holdrst_busy", {31'd0, busy}, 32'd0);
        chk("holdrst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        send_vec(18'h00800, 16);
        collect("post_rst", 18'h08000, 1'b0);

`ifdef LFP_ACC_BIAS_EN
        // Bias -2.0 plus 16 x 1.0 = 14.0, persists, mid-vector load ignored
        bias_q    = 18'h3F000;
        bias_load = 1'b1;
        tick();
        bias_load = 1'b0;
        send_vec(18'h00800, 16);
        collect("bias_first", 18'h07000, 1'b0);
        send_vec(18'h00800, 16);
        collect("bias_persist", 18'h07000, 1'b0);
        send_vec(18'h00800, 4);
        bias_q    = 18'h00000;
        bias_load = 1'b1;
        tick();
        bias_load = 1'b0;
        send_vec(18'h00800, 12);
        collect("bias_midload", 18'h07000, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
